// File: rtl/ysyx_220066_pkg.sv
// Shared types for the ysyx_220066 decode stage: control bundle, immediate
// formats, exception cause codes and ALU/branch encodings.
package ysyx_220066_pkg;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       is_mul;
        logic       is_div;
        logic       alu_a_pc;
        logic [1:0] alu_b_sel;
        logic [2:0] branch;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] mem_op;
        logic       reg_wr;
        logic       csr;
        logic       mret;
        logic       word_op;
    } ctrl_t;

    typedef enum logic [2:0] {EXT_I, EXT_S, EXT_B, EXT_U, EXT_J} ext_op_t;

    localparam logic [3:0] CAUSE_IAF     = 4'd1;
    localparam logic [3:0] CAUSE_ILL     = 4'd2;
    localparam logic [3:0] CAUSE_BRK     = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_COPYB = 5'd10;
    // M-extension ops are 5'b10_funct3 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)

    localparam logic [1:0] B_SEL_RS2  = 2'd0;
    localparam logic [1:0] B_SEL_IMM  = 2'd1;
    localparam logic [1:0] B_SEL_FOUR = 2'd2;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_EQ   = 3'b100;
    localparam logic [2:0] BR_NE   = 3'b101;
    localparam logic [2:0] BR_LT   = 3'b110;
    localparam logic [2:0] BR_GE   = 3'b111;

    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ysyx_220066_id_queue_dec_core.sv
// Combinational RV32/RV64 I+M decoder: control bundle, sign-extended
// immediate and the illegal/ecall/ebreak/mret classification.
module ysyx_220066_dec_core
    import ysyx_220066_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic            ecall,
    output logic            ebreak,
    output logic            mret
);

    localparam logic RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    ext_op_t     ext;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        ctrl    = '0;
        ext     = EXT_I;
        illegal = 1'b0;
        ecall   = 1'b0;
        ebreak  = 1'b0;
        mret    = 1'b0;
        if (opcode[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode[6:2])
                5'b01101: begin // lui
                    ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_COPYB;
                    ctrl.alu_b_sel = B_SEL_IMM; ext = EXT_U;
                end
                5'b00101: begin // auipc
                    ctrl.reg_wr = 1'b1; ctrl.alu_a_pc = 1'b1;
                    ctrl.alu_b_sel = B_SEL_IMM; ext = EXT_U;
                end
                5'b11011: begin // jal: ALU computes the link value pc+4
                    ctrl.reg_wr = 1'b1; ctrl.alu_a_pc = 1'b1;
                    ctrl.alu_b_sel = B_SEL_FOUR; ctrl.branch = BR_JAL; ext = EXT_J;
                end
                5'b11001: begin // jalr
                    ctrl.reg_wr = 1'b1; ctrl.alu_a_pc = 1'b1;
                    ctrl.alu_b_sel = B_SEL_FOUR; ctrl.branch = BR_JALR;
                    illegal = (f3 != 3'b000);
                end
                5'b11000: begin // branches compare through the ALU
                    ext = EXT_B;
                    case (f3)
                        3'b000:  begin ctrl.branch = BR_EQ; ctrl.alu_op = ALU_SUB;  end
                        3'b001:  begin ctrl.branch = BR_NE; ctrl.alu_op = ALU_SUB;  end
                        3'b100:  begin ctrl.branch = BR_LT; ctrl.alu_op = ALU_SLT;  end
                        3'b101:  begin ctrl.branch = BR_GE; ctrl.alu_op = ALU_SLT;  end
                        3'b110:  begin ctrl.branch = BR_LT; ctrl.alu_op = ALU_SLTU; end
                        3'b111:  begin ctrl.branch = BR_GE; ctrl.alu_op = ALU_SLTU; end
                        default: illegal = 1'b1;
                    endcase
                end
                5'b00000: begin // loads
                    ctrl.mem_rd = 1'b1; ctrl.reg_wr = 1'b1;
                    ctrl.alu_b_sel = B_SEL_IMM; ctrl.mem_op = f3;
                    illegal = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
                end
                5'b01000: begin // stores
                    ctrl.mem_wr = 1'b1; ctrl.alu_b_sel = B_SEL_IMM;
                    ctrl.mem_op = f3; ext = EXT_S;
                    illegal = f3[2] || (!RV64 && f3 == 3'b011);
                end
                5'b00100: begin // op-imm; shamt[5] only exists on RV64
                    ctrl.reg_wr = 1'b1; ctrl.alu_b_sel = B_SEL_IMM;
                    ctrl.alu_op = alu_from_f3(f3, (f3 == 3'b101) && instr[30]);
                    if (f3 == 3'b001)
                        illegal = (instr[31:26] != 6'd0) || (!RV64 && instr[25]);
                    else if (f3 == 3'b101)
                        illegal = ({instr[31], instr[29:26]} != 5'd0) || (!RV64 && instr[25]);
                end
                5'b00110: begin // op-imm-32
                    ctrl.reg_wr = 1'b1; ctrl.alu_b_sel = B_SEL_IMM; ctrl.word_op = 1'b1;
                    ctrl.alu_op = alu_from_f3(f3, (f3 == 3'b101) && instr[30]);
                    case (f3)
                        3'b000:  illegal = !RV64;
                        3'b001:  illegal = !RV64 || (f7 != 7'd0);
                        3'b101:  illegal = !RV64 || ({f7[6], f7[4:0]} != 6'd0);
                        default: illegal = 1'b1;
                    endcase
                end
                5'b01100: begin // op
                    ctrl.reg_wr = 1'b1; ctrl.alu_b_sel = B_SEL_RS2;
                    if (f7 == 7'b0000001) begin
                        ctrl.is_mul = !f3[2]; ctrl.is_div = f3[2];
                        ctrl.alu_op = {2'b10, f3};
                    end else if (f7 == 7'b0000000) begin
                        ctrl.alu_op = alu_from_f3(f3, 1'b0);
                    end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                        ctrl.alu_op = alu_from_f3(f3, 1'b1);
                    end else begin
                        illegal = 1'b1;
                    end
                end
                5'b01110: begin // op-32
                    ctrl.reg_wr = 1'b1; ctrl.alu_b_sel = B_SEL_RS2; ctrl.word_op = 1'b1;
                    if (f7 == 7'b0000001) begin
                        ctrl.is_mul = !f3[2]; ctrl.is_div = f3[2];
                        ctrl.alu_op = {2'b10, f3};
                        illegal = !RV64 || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
                    end else if (f7 == 7'b0000000) begin
                        ctrl.alu_op = alu_from_f3(f3, 1'b0);
                        illegal = !RV64 || !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
                    end else if (f7 == 7'b0100000) begin
                        ctrl.alu_op = alu_from_f3(f3, 1'b1);
                        illegal = !RV64 || !(f3 == 3'b000 || f3 == 3'b101);
                    end else begin
                        illegal = 1'b1;
                    end
                end
                5'b00011: illegal = (f3[2:1] != 2'b00); // fence / fence.i execute as nops
                5'b11100: begin
                    if (f3 == 3'b000) begin
                        case (instr)
                            32'h0000_0073: ecall  = 1'b1;
                            32'h0010_0073: ebreak = 1'b1;
                            32'h3020_0073: begin mret = 1'b1; ctrl.mret = 1'b1; end
                            default:       illegal = 1'b1;
                        endcase
                    end else if (f3 == 3'b100) begin
                        illegal = 1'b1;
                    end else begin
                        ctrl.csr = 1'b1; ctrl.reg_wr = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (ext)
            EXT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            EXT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            EXT_U:   imm32 = {instr[31:12], 12'd0};
            EXT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = {{20{instr[31]}}, instr[31:20]};
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/ysyx_220066_id_queue.sv
// Decode stage: DEPTH-entry circular instruction queue between fetch and
// execute, with the head decoded combinationally into control and exceptions.
module ysyx_220066_id_queue
    import ysyx_220066_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_fetch_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output ctrl_t           out_ctrl,
    output logic            out_exc,
    output logic [3:0]      out_cause,
    output logic [CNTW-1:0] out_count
);

    localparam int PW = $clog2(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready depends only on occupancy, never on out_ready.
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic            err_mem   [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CNTW-1:0] count;
    logic            push, pop;

    assign in_ready  = (count != CNTW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_count = count;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
            err_mem[wr_ptr]   <= in_fetch_err;
        end
    end

    logic [31:0] head_instr;
    logic        head_err;
    ctrl_t       dec_ctrl;
    logic        dec_illegal, dec_ecall, dec_ebreak, dec_mret;

    assign head_instr = instr_mem[rd_ptr];
    assign head_err   = err_mem[rd_ptr];
    assign out_pc     = pc_mem[rd_ptr];
    assign out_rd     = head_instr[11:7];
    assign out_rs1    = head_instr[19:15];
    assign out_rs2    = head_instr[24:20];

    ysyx_220066_dec_core #(.XLEN(XLEN)) u_dec (
        .instr   (head_instr),
        .ctrl    (dec_ctrl),
        .imm     (out_imm),
        .illegal (dec_illegal),
        .ecall   (dec_ecall),
        .ebreak  (dec_ebreak),
        .mret    (dec_mret)
    );

    // A fetch fault overrides everything the instruction bits claim, mret included.
    always_comb begin
        out_ctrl      = dec_ctrl;
        out_ctrl.mret = dec_mret && !head_err;
        out_exc       = out_valid && (head_err || dec_illegal || dec_ebreak || dec_ecall);
        if (head_err)         out_cause = CAUSE_IAF;
        else if (dec_illegal) out_cause = CAUSE_ILL;
        else if (dec_ebreak)  out_cause = CAUSE_BRK;
        else if (dec_ecall)   out_cause = CAUSE_ECALL_M;
        else                  out_cause = 4'd0;
    end

endmodule

// File: tb/tb_ysyx_220066_id_queue.sv
// Bench for ysyx_220066_id_queue: RV64 and RV32 instances share stimulus and
// are checked against an ISA-table reference model through expected queues.
module tb_ysyx_220066_id_queue;
    import ysyx_220066_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNTW  = 3;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, in_fetch_err;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic            a_in_ready, a_out_valid, a_exc;
    logic [63:0]     a_pc, a_imm;
    logic [4:0]      a_rd, a_rs1, a_rs2;
    ctrl_t           a_ctrl;
    logic [3:0]      a_cause;
    logic [CNTW-1:0] a_count;

    logic            b_in_ready, b_out_valid, b_exc;
    logic [31:0]     b_pc, b_imm;
    logic [4:0]      b_rd, b_rs1, b_rs2;
    ctrl_t           b_ctrl;
    logic [3:0]      b_cause;
    logic [CNTW-1:0] b_count;

    ysyx_220066_id_queue #(.XLEN(64), .DEPTH(DEPTH)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_fetch_err(in_fetch_err),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc), .out_rd(a_rd),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm), .out_ctrl(a_ctrl),
        .out_exc(a_exc), .out_cause(a_cause), .out_count(a_count)
    );

    ysyx_220066_id_queue #(.XLEN(32), .DEPTH(DEPTH)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_fetch_err(in_fetch_err),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc), .out_rd(b_rd),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm), .out_ctrl(b_ctrl),
        .out_exc(b_exc), .out_cause(b_cause), .out_count(b_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rv64_only;
        logic [31:0] mask;
        logic [31:0] match;
    } pat_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic        exc;
        logic [3:0]  cause;
        logic        chk_ctrl;
        logic        chk_imm;
        logic        mem_rd, mem_wr, reg_wr, mret, word_op, is_mul, is_div;
        logic [2:0]  branch;
    } exp_t;

    pat_t pat_q[$];
    exp_t q64[$];
    exp_t q32[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] cur_instr = '0;

    task automatic add_pat(input logic rv, input logic [31:0] m, input logic [31:0] v);
        pat_t p;
        p.rv64_only = rv; p.mask = m; p.match = v;
        pat_q.push_back(p);
    endtask

    // The instruction set as mask/match pairs from the ISA opcode listing.
    task automatic build_isa();
        logic [31:0] U7, IM, RM, S6, FM, MM;
        U7 = 32'h0000_007F; IM = 32'h0000_707F; RM = 32'hFE00_707F;
        S6 = 32'hFC00_707F; FM = 32'hFFFF_FFFF; MM = 32'hFE00_007F;
        add_pat(0, U7, 32'h37); add_pat(0, U7, 32'h17); add_pat(0, U7, 32'h6F); add_pat(0, IM, 32'h67);
        add_pat(0, IM, 32'h63); add_pat(0, IM, 32'h1063); add_pat(0, IM, 32'h4063);
        add_pat(0, IM, 32'h5063); add_pat(0, IM, 32'h6063); add_pat(0, IM, 32'h7063);
        add_pat(0, IM, 32'h03); add_pat(0, IM, 32'h1003); add_pat(0, IM, 32'h2003);
        add_pat(0, IM, 32'h4003); add_pat(0, IM, 32'h5003); add_pat(1, IM, 32'h3003); add_pat(1, IM, 32'h6003);
        add_pat(0, IM, 32'h23); add_pat(0, IM, 32'h1023); add_pat(0, IM, 32'h2023); add_pat(1, IM, 32'h3023);
        add_pat(0, IM, 32'h13); add_pat(0, IM, 32'h2013); add_pat(0, IM, 32'h3013);
        add_pat(0, IM, 32'h4013); add_pat(0, IM, 32'h6013); add_pat(0, IM, 32'h7013);
        add_pat(0, RM, 32'h1013); add_pat(0, RM, 32'h5013); add_pat(0, RM, 32'h4000_5013);
        add_pat(1, S6, 32'h1013); add_pat(1, S6, 32'h5013); add_pat(1, S6, 32'h4000_5013);
        add_pat(1, IM, 32'h1B); add_pat(1, RM, 32'h101B); add_pat(1, RM, 32'h501B); add_pat(1, RM, 32'h4000_501B);
        add_pat(0, RM, 32'h33); add_pat(0, RM, 32'h4000_0033); add_pat(0, RM, 32'h1033);
        add_pat(0, RM, 32'h2033); add_pat(0, RM, 32'h3033); add_pat(0, RM, 32'h4033);
        add_pat(0, RM, 32'h5033); add_pat(0, RM, 32'h4000_5033); add_pat(0, RM, 32'h6033);
        add_pat(0, RM, 32'h7033); add_pat(0, MM, 32'h0200_0033);
        add_pat(1, RM, 32'h3B); add_pat(1, RM, 32'h4000_003B); add_pat(1, RM, 32'h103B);
        add_pat(1, RM, 32'h503B); add_pat(1, RM, 32'h4000_503B); add_pat(1, RM, 32'h0200_003B);
        add_pat(1, RM, 32'h0200_403B); add_pat(1, RM, 32'h0200_503B); add_pat(1, RM, 32'h0200_603B);
        add_pat(1, RM, 32'h0200_703B);
        add_pat(0, IM, 32'h0F); add_pat(0, IM, 32'h100F);
        add_pat(0, FM, 32'h73); add_pat(0, FM, 32'h0010_0073); add_pat(0, FM, 32'h3020_0073);
        add_pat(0, IM, 32'h1073); add_pat(0, IM, 32'h2073); add_pat(0, IM, 32'h3073);
        add_pat(0, IM, 32'h5073); add_pat(0, IM, 32'h6073); add_pat(0, IM, 32'h7073);
    endtask

    function automatic bit is_legal(input logic [31:0] ins, input bit rv64);
        foreach (pat_q[i])
            if ((ins & pat_q[i].mask) == pat_q[i].match && (rv64 || !pat_q[i].rv64_only))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        logic signed [63:0] t;
        t = v << (64 - bits);
        return t >>> (64 - bits);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                        input logic err, input bit rv64);
        exp_t e;
        bit   legal;
        logic [6:0] op;
        logic [2:0] f3;
        legal = is_legal(ins, rv64);
        op = ins[6:0];
        f3 = ins[14:12];
        e = '0;
        e.instr = ins;
        e.pc    = rv64 ? pc : {32'd0, pc[31:0]};
        e.exc   = 1'b1;
        if (err)                      e.cause = 4'd1;
        else if (!legal)              e.cause = 4'd2;
        else if (ins == 32'h0010_0073) e.cause = 4'd3;
        else if (ins == 32'h0000_0073) e.cause = 4'd11;
        else                          e.exc = 1'b0;
        e.mret     = (ins == 32'h3020_0073) && !err;
        e.chk_ctrl = legal && !err;
        e.chk_imm  = e.chk_ctrl && op != 7'h33 && op != 7'h3B;
        e.mem_rd   = (op == 7'h03);
        e.mem_wr   = (op == 7'h23);
        e.reg_wr   = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h33, 7'h3B})
                     || (op == 7'h73 && f3 != 3'd0);
        e.word_op  = (op == 7'h1B || op == 7'h3B);
        e.is_mul   = (op == 7'h33 || op == 7'h3B) && ins[31:25] == 7'd1 && !f3[2];
        e.is_div   = (op == 7'h33 || op == 7'h3B) && ins[31:25] == 7'd1 && f3[2];
        case (op)
            7'h6F:   e.branch = 3'b001;
            7'h67:   e.branch = 3'b010;
            7'h63:   e.branch = (f3 == 3'd0) ? 3'b100 : (f3 == 3'd1) ? 3'b101 : (f3[0] ? 3'b111 : 3'b110);
            default: e.branch = 3'b000;
        endcase
        case (op)
            7'h23:        e.imm = sext({ins[31:25], ins[11:7]}, 12);
            7'h63:        e.imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            7'h37, 7'h17: e.imm = sext({ins[31:12], 12'd0}, 32);
            7'h6F:        e.imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            default:      e.imm = sext(ins[31:20], 12);
        endcase
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s instr=%h t=%0t: got %h expected %h", name, cur_instr, $time, act, exp);
        end
    endtask

    task automatic cmp64(input exp_t e);
        cur_instr = e.instr;
        chk("pc64", a_pc, e.pc);
        chk("rd64", a_rd, e.instr[11:7]);
        chk("rs1_64", a_rs1, e.instr[19:15]);
        chk("rs2_64", a_rs2, e.instr[24:20]);
        chk("exc64", a_exc, e.exc);
        if (e.exc) chk("cause64", a_cause, e.cause);
        chk("mret64", a_ctrl.mret, e.mret);
        if (e.chk_ctrl) begin
            chk("mem_rd64", a_ctrl.mem_rd, e.mem_rd);
            chk("mem_wr64", a_ctrl.mem_wr, e.mem_wr);
            chk("reg_wr64", a_ctrl.reg_wr, e.reg_wr);
            chk("word_op64", a_ctrl.word_op, e.word_op);
            chk("is_mul64", a_ctrl.is_mul, e.is_mul);
            chk("is_div64", a_ctrl.is_div, e.is_div);
            chk("branch64", a_ctrl.branch, e.branch);
        end
        if (e.chk_imm) chk("imm64", a_imm, e.imm);
    endtask

    task automatic cmp32(input exp_t e);
        cur_instr = e.instr;
        chk("pc32", b_pc, e.pc[31:0]);
        chk("rd32", b_rd, e.instr[11:7]);
        chk("exc32", b_exc, e.exc);
        if (e.exc) chk("cause32", b_cause, e.cause);
        chk("mret32", b_ctrl.mret, e.mret);
        if (e.chk_ctrl) begin
            chk("mem_rd32", b_ctrl.mem_rd, e.mem_rd);
            chk("mem_wr32", b_ctrl.mem_wr, e.mem_wr);
            chk("reg_wr32", b_ctrl.reg_wr, e.reg_wr);
            chk("branch32", b_ctrl.branch, e.branch);
        end
        if (e.chk_imm) chk("imm32", b_imm, e.imm[31:0]);
    endtask

    // Occupancy model plus monitor: checks handshake outputs every cycle and
    // compares the head against the expected queue whenever it pops.
    int cnt   = 0;
    bit armed = 1'b0;
    always @(negedge clk) begin
        bit do_push, do_pop;
        if (armed) begin
            chk("in_ready64", a_in_ready, cnt != DEPTH);
            chk("in_ready32", b_in_ready, cnt != DEPTH);
            chk("out_valid64", a_out_valid, cnt != 0);
            chk("out_valid32", b_out_valid, cnt != 0);
            chk("count64", a_count, cnt);
            chk("count32", b_count, cnt);
            if (cnt == 0) begin
                chk("exc_idle64", a_exc, 1'b0);
                chk("exc_idle32", b_exc, 1'b0);
            end
        end
        if (!rst) begin
            q64.delete(); q32.delete(); cnt = 0; armed = 1'b1;
        end else if (flush) begin
            q64.delete(); q32.delete(); cnt = 0;
        end else if (armed) begin
            do_pop  = (cnt != 0) && out_ready;
            do_push = in_valid && (cnt != DEPTH);
            if (do_pop && q64.size() > 0 && q32.size() > 0) begin
                cmp64(q64.pop_front());
                cmp32(q32.pop_front());
            end
            if (do_push) begin
                q64.push_back(ref_decode(in_instr, in_pc, in_fetch_err, 1'b1));
                q32.push_back(ref_decode(in_instr, in_pc, in_fetch_err, 1'b0));
            end
            cnt = cnt + int'(do_push) - int'(do_pop);
        end
    end

    // ---------------- driver ----------------
    logic [63:0] pc_ctr = 64'h8000_0000;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic err);
        in_valid = 1'b1; in_instr = ins; in_fetch_err = err; in_pc = pc_ctr;
        pc_ctr = pc_ctr + 64'd4;
        cyc();
        in_valid = 1'b0; in_fetch_err = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        int   k;
        pat_t p;
        k = $urandom_range(0, 9);
        if (k <= 5) begin
            p = pat_q[$urandom_range(0, pat_q.size() - 1)];
            return p.match | ($urandom & ~p.mask);
        end else if (k <= 7) begin
            return {$urandom_range(0, 32'h01FF_FFFF), 7'h0} | {25'd0, 7'($urandom_range(0, 127))};
        end else begin
            return $urandom;
        end
    endfunction

    initial begin
        build_isa();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_fetch_err = 1'b0; in_instr = '0; in_pc = '0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        // first entry, then pop it
        out_ready = 1'b1;
        offer(32'h0050_0093, 1'b0);
        cyc();

        // fill to DEPTH, then stream with in_valid held across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) offer(32'h0010_0093 + (32'(i) << 20), 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_instr = 32'h0000_0113 + (32'(i) << 20); in_pc = pc_ctr;
            pc_ctr = pc_ctr + 64'd4;
            cyc();
        end
        in_valid = 1'b0;
        repeat (DEPTH + 1) cyc();

        // flush with a simultaneous push while holding 3 entries
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) offer(32'h0000_0013, 1'b0);
        flush = 1'b1;
        offer(32'h0070_0393, 1'b0);
        flush = 1'b0;
        repeat (2) cyc();

        // exception classification, RV32/RV64 legality and branch immediate
        out_ready = 1'b1;
        offer(32'h0000_B083, 1'b0);
        offer(32'h0000_0073, 1'b1);
        offer(32'h0000_0073, 1'b0);
        offer(32'h0010_0073, 1'b0);
        offer(32'h3020_0073, 1'b0);
        offer(32'hFE00_0EE3, 1'b0);
        offer(32'h0200_0093, 1'b0);
        offer(32'h0000_0092, 1'b0);
        repeat (3) cyc();

        // randomized traffic with occasional flush and mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 39) == 0);
            rst          = ($urandom_range(0, 299) != 0);
            in_fetch_err = ($urandom_range(0, 15) == 0);
            in_instr     = rand_instr();
            in_pc        = {$urandom, $urandom} & ~64'h3;
            cyc();
        end
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_fetch_err = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 2) cyc();
        chk("drain64", 64'(q64.size()), 64'd0);
        chk("drain32", 64'(q32.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_id_queue.md
# ysyx_220066_id_queue

Parametrised decode stage with a built-in instruction queue, sitting between fetch and execute in the ysyx_220066 core. It buffers up to DEPTH fetched instructions under valid/ready handshakes on both sides. It decodes the queue head combinationally into a control bundle and sign-extended immediate, and classifies exceptions with RISC-V cause codes. XLEN selects RV64I+M or RV32I+M legality.

## Interface
Parameters:
- XLEN, 64, architectural width; only 32 or 64 are legal values.
- DEPTH, 4, queue entries; must be a power of two and at least 2.
- CNTW, $clog2(DEPTH)+1, occupancy counter width (derived).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-low: state clears on the rising edge of clk while rst=0.
- flush  in  1  discard all queued entries (redirect or trap).
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue accepts an entry.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- in_fetch_err  in  1  access fault during fetch.
- out_valid  out  1  decoded head is valid.
- out_ready  in  1  execute consumes the head.
- out_pc  out  XLEN  head PC.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  immediate, sign-extended to XLEN.
- out_ctrl  out  ctrl_t  decoded control bundle (see Structure).
- out_exc  out  1  head raises an exception.
- out_cause  out  4  exception cause code.
- out_count  out  CNTW  current occupancy.

## Operation
- The queue is a circular buffer with a read pointer, a write pointer (both log2(DEPTH) bits, wrap naturally) and a count.
- in_ready = (count != DEPTH). There is no pass-through when full, even if the head pops in the same cycle.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- Simultaneous push and pop leaves count unchanged; both pointers advance.
- out_valid = (count != 0). All out_* fields derive combinationally from the head entry; they are don't-care when out_valid=0.
- flush has priority over push and pop in the same cycle: count and both pointers return to 0, and the push in that cycle is dropped.
- Reset has priority over flush.
- Exception priority, highest first:
  - fetch error → cause 1;
  - illegal instruction → cause 2;
  - ebreak → cause 3;
  - ecall → cause 11.
- mret sets ctrl.mret with out_exc=0.
- Illegal instruction includes:
  - opcode[1:0] != 2'b11;
  - unknown opcode or funct3/funct7 combination;
  - SYSTEM funct3=000 that is not ecall, ebreak or mret;
  - jalr with funct3 != 0.
- Additional illegal instructions when XLEN=32:
  - OP-IMM-32 (0011011) and OP-32 (0111011);
  - ld, lwu, sd;
  - shift-immediate with shamt[5]=1.
- Immediate formats: I, S, B, U, J, per the RISC-V base ISA, sign-extended from bit 31 to XLEN.

## Timing
- Reset: count=0, pointers=0, in_ready=1, out_valid=0, out_count=0, out_exc=0.
- Latency: an entry pushed at edge N is visible at out_* after edge N (earliest pop in cycle N+1).
- Throughput: 1 entry per cycle sustained when out_ready=1.
- Holding out_ready=0 leaves the head stable until it pops or the queue is flushed.
- A flush asserted in cycle N gives out_valid=0 and in_ready=1 from cycle N+1.
- Reset asserted mid-stream behaves like a flush.

## Structure
- Package ysyx_220066_pkg holds:
  - ctrl_t fields: alu_op[4:0], is_mul, is_div, alu_a_pc, alu_b_sel[1:0], branch[2:0], mem_rd, mem_wr, mem_op[2:0], reg_wr, csr, mret, word_op;
  - ext_op enum: I, S, B, U, J;
  - cause constants: CAUSE_IAF=1, CAUSE_ILL=2, CAUSE_BRK=3, CAUSE_ECALL_M=11.
- Sub-module ysyx_220066_dec_core (parameter XLEN): purely combinational decoder from instruction to ctrl, imm, illegal, ecall, ebreak and mret.
- The queue and handshake logic live in the top module.

## Test plan
- Reset, then push addi x1,x0,5 (0x00500093) at pc 0x80000000 → next cycle out_valid=1, out_imm=5, out_rd=1, out_exc=0.
- Push DEPTH entries with out_ready=0 → in_ready=0 and out_count=DEPTH. Then hold in_valid=1 and out_ready=1 → exactly one pop per cycle, no entry lost, order preserved across pointer wrap.
- With the queue holding 3 entries, assert flush together with in_valid=1 → next cycle out_count=0 and the pushed entry is discarded.
- XLEN=32: push ld (0x0000B083) → out_exc=1, cause=2. XLEN=64: the same instruction gives out_exc=0 and ctrl.mem_rd=1.
- Push 0x00000073 with in_fetch_err=1 → cause=1. Push 0x00000073 with in_fetch_err=0 → cause=11. Push 0x00100073 → cause=3. Push 0x30200073 → out_exc=0, ctrl.mret=1.
- Push beq with imm −4 (0xFE000EE3) → out_imm=all-ones…FFFC, ctrl.branch=100.
